tcm_port_arbiter: RTL
=====================

Name: tcm_port_arbiter

Overview:
- Shares the single-ported TCM between three requesters: instruction fetch read, store-buffer read and store-buffer write.
- Sits between the bus and the TCM macro.
- Arbitrates round-robin, rebases addresses by TCM_ADDR and issues one TCM command per cycle.
- Returns read data and acks one cycle after the command is issued.
- Keeps a saturating contention counter for performance analysis.

Parameters:
- ADDR_WIDTH, 32, address width
- BUS_DATA_WIDTH, 64, TCM read data width (one fetch packet)
- REG_DATA_WIDTH, 32, store-buffer data width
- SIZE_WIDTH, 3, access size field width (legal sizes 1, 2, 4)
- TCM_ADDR, 32'h80000000, TCM base address subtracted from every request address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch read request, held until fetch_ack
- fetch_addr  in  ADDR_WIDTH  fetch address, absolute
- fetch_ack  out  1  fetch data valid
- fetch_data  out  BUS_DATA_WIDTH  fetch read data
- stbuf_rd_req  in  1  store-buffer read request, held until ack
- stbuf_rd_addr  in  ADDR_WIDTH  store-buffer read address
- stbuf_rd_size  in  SIZE_WIDTH  store-buffer read size in bytes
- stbuf_rd_ack  out  1  store-buffer read data valid
- stbuf_rd_data  out  REG_DATA_WIDTH  size-masked, zero-extended read data
- stbuf_wr_req  in  1  store-buffer write request, held until ack
- stbuf_wr_addr  in  ADDR_WIDTH  store-buffer write address
- stbuf_wr_size  in  SIZE_WIDTH  store-buffer write size in bytes
- stbuf_wr_data  in  REG_DATA_WIDTH  store-buffer write data
- stbuf_wr_ack  out  1  write completed
- tcm_addr  out  ADDR_WIDTH  rebased address (request address - TCM_ADDR)
- tcm_rd  out  1  TCM read strobe
- tcm_wr  out  1  TCM write strobe
- tcm_size  out  SIZE_WIDTH  TCM access size
- tcm_wdata  out  REG_DATA_WIDTH  TCM write data
- tcm_rdata  in  BUS_DATA_WIDTH  TCM read data, valid the cycle after tcm_rd
- stall_cnt  out  32  saturating contention counter

Behaviour:
- Requester indices: 0 = fetch, 1 = stbuf_rd, 2 = stbuf_wr.
- Registered state, all cleared asynchronously when rst=0:
  - rr_ptr (2 bits, reset 0): the highest-priority index.
  - inflight_vld (reset 0) and inflight_id (reset 0).
  - inflight_size (reset 0).
  - stall_cnt (reset 0).
- Eligible set: each asserted req, with requester inflight_id masked while inflight_vld=1. This prevents re-granting a requester in its response cycle, while its req is still high.
- Grant, combinational:
  - The first eligible index scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - At most one grant per cycle.
  - On a grant g: rr_ptr <= (g+1) mod 3.
- TCM command, combinational, same cycle as the grant:
  - Grant 0: tcm_rd=1, tcm_size=4.
  - Grant 1: tcm_rd=1, tcm_size=stbuf_rd_size.
  - Grant 2: tcm_wr=1, tcm_size=stbuf_wr_size, tcm_wdata=stbuf_wr_data.
  - tcm_addr = granted address - TCM_ADDR, modulo 2^ADDR_WIDTH.
  - No grant: tcm_rd=tcm_wr=0, tcm_addr=0, tcm_size=0, tcm_wdata=0.
- Response: on a grant, inflight_vld <= 1, inflight_id <= g, inflight_size <= tcm_size; otherwise inflight_vld <= 0.
- Acks are decoded from the registered inflight state, so each is exactly one cycle wide, in cycle N+1 for a grant in cycle N:
  - fetch_ack = inflight_vld & id==0.
  - stbuf_rd_ack = inflight_vld & id==1.
  - stbuf_wr_ack = inflight_vld & id==2.
- Read data, combinational from tcm_rdata:
  - fetch_data = tcm_rdata when fetch_ack, else 0.
  - stbuf_rd_data when stbuf_rd_ack: size 1 → {24'b0, rdata[7:0]}; size 2 → {16'b0, rdata[15:0]}; size 4 → rdata[31:0]; any other size → 0. When stbuf_rd_ack=0 it is 0.
- Throughput: back-to-back grants to different requesters every cycle. A single requester gets at most one grant every 2 cycles.
- stall_cnt increments by 1 each cycle in which at least one req is high and its requester is not granted, unless it is already 32'hFFFFFFFF, where it saturates.
- A req dropped during its response cycle still gets its ack.
- Reset asserted mid-transaction: in-flight ack is discarded, all acks are 0 and the TCM strobes are 0 while rst=0. No ack follows reset deassertion.
- Outputs at reset: all acks 0, tcm_rd/tcm_wr 0, stall_cnt 0, data outputs 0.

Test Plan:
- Single fetch: fetch_req=1, fetch_addr=0x80000010 → same cycle tcm_rd=1, tcm_addr=0x10, tcm_size=4. Next cycle fetch_ack=1, fetch_data=tcm_rdata (e.g. 0x0000_0013_0000_0093).
- Byte read: stbuf_rd_addr=0x80000103, size=1, tcm_rdata=0x...AABBCCDD → stbuf_rd_ack next cycle, stbuf_rd_data=0x000000DD. Repeat with size=2 → 0x0000CCDD.
- Three-way contention from reset, all reqs held, each dropped after its ack:
  - Grants fetch, stbuf_rd, stbuf_wr in cycles 0, 1, 2.
  - Acks in cycles 1, 2, 3.
  - stall_cnt = 2 + 1 = 3 after cycle 2.
- Round robin with a persistent fetch: fetch and stbuf_wr both held continuously → grants alternate 0, 2, 0, 2. No requester waits more than 2 cycles.
- Write: stbuf_wr_addr=0x80000200, size=4, data=0xDEADBEEF → tcm_wr=1, tcm_addr=0x200, tcm_wdata=0xDEADBEEF, tcm_size=4. stbuf_wr_ack=1 next cycle for exactly 1 cycle.
- Async reset mid-read: grant fetch, drop rst to 0 before the next edge → fetch_ack stays 0 and rr_ptr returns to 0. After release, a new stbuf_rd request completes normally.

Source files
------------

// File: rtl/tcm_port_arbiter_if.sv
// Requester-side and TCM-side signal bundle of the TCM port arbiter.
// master = requesters plus TCM macro (testbench side), slave = the arbiter.
interface tcm_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH     = 3
);
  logic                      fetch_req;
  logic [ADDR_WIDTH-1:0]     fetch_addr;
  logic                      fetch_ack;
  logic [BUS_DATA_WIDTH-1:0] fetch_data;

  logic                      stbuf_rd_req;
  logic [ADDR_WIDTH-1:0]     stbuf_rd_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_rd_size;
  logic                      stbuf_rd_ack;
  logic [REG_DATA_WIDTH-1:0] stbuf_rd_data;

  logic                      stbuf_wr_req;
  logic [ADDR_WIDTH-1:0]     stbuf_wr_addr;
  logic [SIZE_WIDTH-1:0]     stbuf_wr_size;
  logic [REG_DATA_WIDTH-1:0] stbuf_wr_data;
  logic                      stbuf_wr_ack;

  logic [ADDR_WIDTH-1:0]     tcm_addr;
  logic                      tcm_rd;
  logic                      tcm_wr;
  logic [SIZE_WIDTH-1:0]     tcm_size;
  logic [REG_DATA_WIDTH-1:0] tcm_wdata;
  logic [BUS_DATA_WIDTH-1:0] tcm_rdata;

  logic [31:0]               stall_cnt;

  modport master (
    output fetch_req, fetch_addr,
    output stbuf_rd_req, stbuf_rd_addr, stbuf_rd_size,
    output stbuf_wr_req, stbuf_wr_addr, stbuf_wr_size, stbuf_wr_data,
    output tcm_rdata,
    input  fetch_ack, fetch_data, stbuf_rd_ack, stbuf_rd_data, stbuf_wr_ack,
    input  tcm_addr, tcm_rd, tcm_wr, tcm_size, tcm_wdata, stall_cnt
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  stbuf_rd_req, stbuf_rd_addr, stbuf_rd_size,
    input  stbuf_wr_req, stbuf_wr_addr, stbuf_wr_size, stbuf_wr_data,
    input  tcm_rdata,
    output fetch_ack, fetch_data, stbuf_rd_ack, stbuf_rd_data, stbuf_wr_ack,
    output tcm_addr, tcm_rd, tcm_wr, tcm_size, tcm_wdata, stall_cnt
  );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Round-robin arbiter sharing the single-ported TCM between fetch, store-buffer
// read and store-buffer write; one command per cycle, response one cycle later.
module tcm_port_arbiter #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           BUS_DATA_WIDTH = 64,
  parameter int unsigned           REG_DATA_WIDTH = 32,
  parameter int unsigned           SIZE_WIDTH     = 3,
  parameter logic [ADDR_WIDTH-1:0] TCM_ADDR       = 32'h8000_0000
) (
  input logic               clk,
  input logic               rst,
  tcm_port_arbiter_if.slave bus
);

  localparam logic [SIZE_WIDTH-1:0] SZ_1 = SIZE_WIDTH'(3'd1);
  localparam logic [SIZE_WIDTH-1:0] SZ_2 = SIZE_WIDTH'(3'd2);
  localparam logic [SIZE_WIDTH-1:0] SZ_4 = SIZE_WIDTH'(3'd4);

  // (ptr + off) mod 3, for ptr and off in 0..2
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  logic [1:0]                r_rr_ptr;
  logic                      r_inflight_vld;
  logic [1:0]                r_inflight_id;
  logic [SIZE_WIDTH-1:0]     r_inflight_size;
  logic [31:0]               r_stall_cnt;

  logic [2:0]                w_req;
  logic [2:0]                w_mask;
  logic [3:0]                w_elig;
  logic [1:0]                w_idx0, w_idx1, w_idx2;
  logic                      w_gnt_vld;
  logic [1:0]                w_gnt_id;
  logic [2:0]                w_gnt_onehot;
  logic                      w_stall_evt;
  logic                      w_tcm_rd, w_tcm_wr;
  logic [ADDR_WIDTH-1:0]     w_tcm_addr;
  logic [SIZE_WIDTH-1:0]     w_tcm_size;
  logic [REG_DATA_WIDTH-1:0] w_tcm_wdata;
  logic                      w_fetch_ack, w_rd_ack, w_wr_ack;
  logic [REG_DATA_WIDTH-1:0] w_rd_data;

  assign w_req = {bus.stbuf_wr_req, bus.stbuf_rd_req, bus.fetch_req};

  // Mask the requester in its response cycle so a still-high req is not re-granted
  always_comb begin
    w_mask = 3'b000;
    if (r_inflight_vld) begin
      case (r_inflight_id)
        2'd0:    w_mask = 3'b001;
        2'd1:    w_mask = 3'b010;
        2'd2:    w_mask = 3'b100;
        default: w_mask = 3'b000;
      endcase
    end else begin
      w_mask = 3'b000;
    end
  end

  // Nothing is granted while reset is held, so the TCM strobes stay quiet
  assign w_elig = rst ? {1'b0, w_req & ~w_mask} : 4'b0000;
  assign w_idx0 = rr_idx(r_rr_ptr, 2'd0);
  assign w_idx1 = rr_idx(r_rr_ptr, 2'd1);
  assign w_idx2 = rr_idx(r_rr_ptr, 2'd2);

  // Round-robin pick: first eligible index starting at r_rr_ptr
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 2'd0;
    if (w_elig[w_idx0]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_idx0;
    end else if (w_elig[w_idx1]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_idx1;
    end else if (w_elig[w_idx2]) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = w_idx2;
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 2'd0;
    end
  end

  // Grant one-hot and contention event
  always_comb begin
    w_gnt_onehot = 3'b000;
    if (w_gnt_vld) begin
      case (w_gnt_id)
        2'd0:    w_gnt_onehot = 3'b001;
        2'd1:    w_gnt_onehot = 3'b010;
        2'd2:    w_gnt_onehot = 3'b100;
        default: w_gnt_onehot = 3'b000;
      endcase
    end else begin
      w_gnt_onehot = 3'b000;
    end
    w_stall_evt = |(w_req & ~w_gnt_onehot);
  end

  // TCM command for the granted requester, address rebased to the macro
  always_comb begin
    w_tcm_rd    = 1'b0;
    w_tcm_wr    = 1'b0;
    w_tcm_addr  = '0;
    w_tcm_size  = '0;
    w_tcm_wdata = '0;
    if (w_gnt_vld) begin
      case (w_gnt_id)
        2'd0: begin
          w_tcm_rd   = 1'b1;
          w_tcm_addr = bus.fetch_addr - TCM_ADDR;
          w_tcm_size = SZ_4;
        end
        2'd1: begin
          w_tcm_rd   = 1'b1;
          w_tcm_addr = bus.stbuf_rd_addr - TCM_ADDR;
          w_tcm_size = bus.stbuf_rd_size;
        end
        2'd2: begin
          w_tcm_wr    = 1'b1;
          w_tcm_addr  = bus.stbuf_wr_addr - TCM_ADDR;
          w_tcm_size  = bus.stbuf_wr_size;
          w_tcm_wdata = bus.stbuf_wr_data;
        end
        default: begin
          w_tcm_rd    = 1'b0;
          w_tcm_wr    = 1'b0;
        end
      endcase
    end else begin
      w_tcm_rd = 1'b0;
      w_tcm_wr = 1'b0;
    end
  end

  // Arbitration pointer and in-flight response tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr        <= 2'd0;
      r_inflight_vld  <= 1'b0;
      r_inflight_id   <= 2'd0;
      r_inflight_size <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr        <= rr_idx(w_gnt_id, 2'd1);
      r_inflight_vld  <= 1'b1;
      r_inflight_id   <= w_gnt_id;
      r_inflight_size <= w_tcm_size;
    end else begin
      r_inflight_vld  <= 1'b0;
    end
  end

  // Saturating contention counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign w_fetch_ack = r_inflight_vld && (r_inflight_id == 2'd0);
  assign w_rd_ack    = r_inflight_vld && (r_inflight_id == 2'd1);
  assign w_wr_ack    = r_inflight_vld && (r_inflight_id == 2'd2);

  // Size-masked, zero-extended store-buffer read data
  always_comb begin
    w_rd_data = '0;
    if (w_rd_ack) begin
      case (r_inflight_size)
        SZ_1:    w_rd_data = REG_DATA_WIDTH'(bus.tcm_rdata[7:0]);
        SZ_2:    w_rd_data = REG_DATA_WIDTH'(bus.tcm_rdata[15:0]);
        SZ_4:    w_rd_data = bus.tcm_rdata[REG_DATA_WIDTH-1:0];
        default: w_rd_data = '0;
      endcase
    end else begin
      w_rd_data = '0;
    end
  end

  assign bus.tcm_rd        = w_tcm_rd;
  assign bus.tcm_wr        = w_tcm_wr;
  assign bus.tcm_addr      = w_tcm_addr;
  assign bus.tcm_size      = w_tcm_size;
  assign bus.tcm_wdata     = w_tcm_wdata;
  assign bus.fetch_ack     = w_fetch_ack;
  assign bus.fetch_data    = w_fetch_ack ? bus.tcm_rdata : '0;
  assign bus.stbuf_rd_ack  = w_rd_ack;
  assign bus.stbuf_rd_data = w_rd_data;
  assign bus.stbuf_wr_ack  = w_wr_ack;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule
